// File: rtl/debug_clock_controller.sv
// Debug clock controller: issues a one-cycle CPU clock-enable in free-run, single-step
// or N-step burst mode, halting on enabled PC breakpoints.
module debug_clock_controller #(
    parameter int DIV_WIDTH  = 24,
    parameter int STEP_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_BP     = 4,
    localparam int IDX_WIDTH = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_auto_en,
    input  logic                         clk_step,
    input  logic [STEP_WIDTH-1:0]        step_count,
    input  logic [DIV_WIDTH-1:0]         div_ratio,
    input  logic [ADDR_WIDTH-1:0]        pc,
    input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr,
    input  logic [NUM_BP-1:0]            bp_en,
    output logic                         cpu_ce,
    output logic                         running,
    output logic                         bp_halted,
    output logic [IDX_WIDTH-1:0]         bp_index,
    output logic [STEP_WIDTH-1:0]        steps_left,
    output logic [31:0]                  ce_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BURST,
        HALT_BP
    } state_t;

    state_t                 state;
    logic                   sync1;
    logic                   sync2;
    logic                   sync3;
    logic                   step_req;
    logic [DIV_WIDTH-1:0]   presc;
    logic                   tick;
    logic                   skip_bp;
    logic                   hit;
    logic [IDX_WIDTH-1:0]   hit_idx;

    // clk_step is asynchronous: two flops for metastability, a third for edge detection,
    // and step_req itself registered so a held level yields exactly one request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            step_req <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, so
            // the chain shifts by exactly one stage per clock.
            sync1    <= clk_step;
            sync2    <= sync1;
            sync3    <= sync2;
            step_req <= sync2 & ~sync3;
        end
    end

    assign tick = (presc == div_ratio);

    // Scanning from the top channel down leaves the lowest matching index in hit_idx.
    always_comb begin
        // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en[i] && (bp_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == pc)) begin
                hit     = 1'b1;
                hit_idx = IDX_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cpu_ce     <= 1'b0;
            running    <= 1'b0;
            bp_halted  <= 1'b0;
            bp_index   <= '0;
            steps_left <= '0;
            ce_count   <= '0;
            presc      <= '0;
            skip_bp    <= 1'b0;
        end else begin
            cpu_ce <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clk_auto_en) begin
                        state   <= RUN;
                        running <= 1'b1;
                        skip_bp <= 1'b1;
                        presc   <= '0;
                    end else if (step_req) begin
                        if (step_count <= STEP_WIDTH'(1)) begin
                            cpu_ce   <= 1'b1;
                            ce_count <= ce_count + 32'd1;
                        end else begin
                            state      <= BURST;
                            running    <= 1'b1;
                            skip_bp    <= 1'b1;
                            presc      <= '0;
                            steps_left <= step_count;
                        end
                    end
                end

                RUN: begin
                    if (!clk_auto_en) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        presc   <= '0;
                    end else if (tick) begin
                        presc <= '0;
                        if (hit && !skip_bp) begin
                            state     <= HALT_BP;
                            running   <= 1'b0;
                            bp_halted <= 1'b1;
                            bp_index  <= hit_idx;
                        end else begin
                            cpu_ce   <= 1'b1;
                            ce_count <= ce_count + 32'd1;
                            skip_bp  <= 1'b0;
                        end
                    end else begin
                        presc <= presc + DIV_WIDTH'(1);
                    end
                end

                BURST: begin
                    if (tick) begin
                        presc <= '0;
                        if (hit && !skip_bp) begin
                            state     <= HALT_BP;
                            running   <= 1'b0;
                            bp_halted <= 1'b1;
                            bp_index  <= hit_idx;
                        end else begin
                            cpu_ce     <= 1'b1;
                            ce_count   <= ce_count + 32'd1;
                            skip_bp    <= 1'b0;
                            steps_left <= steps_left - STEP_WIDTH'(1);
                            // The final pulse is still emitted on the way back to IDLE.
                            if (steps_left == STEP_WIDTH'(1)) begin
                                state   <= IDLE;
                                running <= 1'b0;
                            end
                        end
                    end else begin
                        presc <= presc + DIV_WIDTH'(1);
                    end
                end

                HALT_BP: begin
                    // A step leaves the breakpoint unconditionally; no match check here.
                    if (step_req) begin
                        cpu_ce    <= 1'b1;
                        ce_count  <= ce_count + 32'd1;
                        state     <= IDLE;
                        bp_halted <= 1'b0;
                    end else if (!clk_auto_en) begin
                        state     <= IDLE;
                        bp_halted <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_clock_controller.sv
// Self-checking bench for debug_clock_controller: expected cpu_ce cycle numbers are queued
// when stimulus is applied and popped by a monitor as pulses appear.
module tb_debug_clock_controller;

    logic        clk;
    logic        rst;
    logic        clk_auto_en;
    logic        clk_step;
    logic [15:0] step_count;
    logic [23:0] div_ratio;
    logic [7:0]  pc;
    logic [31:0] bp_addr;
    logic [3:0]  bp_en;
    logic        cpu_ce;
    logic        running;
    logic        bp_halted;
    logic [1:0]  bp_index;
    logic [15:0] steps_left;
    logic [31:0] ce_count;

    int unsigned cyc;
    int unsigned exp_q[$];
    int unsigned exp_ce;
    int          total;
    int          bad;
    int unsigned n;

    debug_clock_controller #(
        .DIV_WIDTH(24), .STEP_WIDTH(16), .ADDR_WIDTH(8), .NUM_BP(4)
    ) dut (
        .clk(clk), .rst(rst), .clk_auto_en(clk_auto_en), .clk_step(clk_step),
        .step_count(step_count), .div_ratio(div_ratio), .pc(pc), .bp_addr(bp_addr),
        .bp_en(bp_en), .cpu_ce(cpu_ce), .running(running), .bp_halted(bp_halted),
        .bp_index(bp_index), .steps_left(steps_left), .ce_count(ce_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_ce(input int unsigned at);
        exp_q.push_back(at);
        exp_ce++;
    endtask

    // Scoreboard monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && cpu_ce) begin
            if (exp_q.size() == 0) check("ce_unexpected", {31'd0, cpu_ce}, 32'd0);
            else check("ce_time", cyc, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc = 0; exp_ce = 0; total = 0; bad = 0;
        rst = 1'b0; clk_auto_en = 1'b0; clk_step = 1'b0; step_count = '0;
        div_ratio = '0; pc = 8'h00; bp_addr = {8'h20, 8'h10, 8'h10, 8'h10}; bp_en = 4'b0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ce", {31'd0, cpu_ce}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_halted", {31'd0, bp_halted}, 32'd0);
        check("rst_index", {30'd0, bp_index}, 32'd0);
        check("rst_steps", {16'd0, steps_left}, 32'd0);
        check("rst_count", ce_count, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single step with step_count 0 then 1; held level gives one pulse each.
        for (int sc = 0; sc < 2; sc++) begin
            step_count = 16'(sc);
            @(negedge clk); n = cyc;
            clk_step = 1'b1;
            expect_ce(n + 4);
            repeat (12) @(negedge clk);
            clk_step = 1'b0;
            repeat (4) @(negedge clk);
            check("step_count", ce_count, exp_ce);
            check("step_running", {31'd0, running}, 32'd0);
            check("step_steps", {16'd0, steps_left}, 32'd0);
        end

        // Free run, div 3: pulses every 4th cycle; drop enable on a tick cycle.
        div_ratio = 24'd3;
        @(negedge clk); n = cyc;
        clk_auto_en = 1'b1;
        for (int k = 0; k < 10; k++) expect_ce(n + 5 + 4 * k);
        @(negedge clk);
        check("run_running", {31'd0, running}, 32'd1);
        repeat (43) @(negedge clk);
        clk_auto_en = 1'b0;
        @(negedge clk);
        check("run_stop", {31'd0, running}, 32'd0);
        repeat (6) @(negedge clk);
        check("run_count", ce_count, exp_ce);

        // Burst of 5 at div 0, with clk_auto_en toggled mid-burst.
        div_ratio = 24'd0; step_count = 16'd5;
        @(negedge clk); n = cyc;
        clk_step = 1'b1;
        for (int k = 0; k < 5; k++) expect_ce(n + 5 + k);
        repeat (3) @(negedge clk);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("burst_steps", {16'd0, steps_left}, 32'(5 - j));
            if (j == 1) clk_auto_en = 1'b1;
            if (j == 3) clk_auto_en = 1'b0;
        end
        check("burst_end", {31'd0, running}, 32'd0);
        clk_step = 1'b0;
        repeat (5) @(negedge clk);
        check("burst_count", ce_count, exp_ce);

        // Breakpoint: channels 1 and 2 on 8'h10, channel 0 matches but is disabled.
        bp_en = 4'b0110; div_ratio = 24'd1; pc = 8'h0E;
        @(negedge clk); n = cyc;
        clk_auto_en = 1'b1;
        expect_ce(n + 3); expect_ce(n + 5);
        repeat (3) @(negedge clk); pc = 8'h0F;
        repeat (2) @(negedge clk); pc = 8'h10;
        repeat (2) @(negedge clk);
        check("bp_halted", {31'd0, bp_halted}, 32'd1);
        check("bp_index", {30'd0, bp_index}, 32'd1);
        check("bp_running", {31'd0, running}, 32'd0);
        repeat (4) @(negedge clk);
        check("bp_hold", {31'd0, bp_halted}, 32'd1);

        // Step off the breakpoint, then resume at the same pc: skip rule lets one tick pass.
        step_count = 16'd0;
        @(negedge clk); n = cyc;
        clk_step = 1'b1;
        expect_ce(n + 4); expect_ce(n + 7);
        repeat (4) @(negedge clk);
        check("bpstep_released", {31'd0, bp_halted}, 32'd0);
        repeat (3) @(negedge clk);
        check("skip_no_rehalt", {31'd0, bp_halted}, 32'd0);
        check("skip_running", {31'd0, running}, 32'd1);
        repeat (2) @(negedge clk);
        check("skip_rehalt", {31'd0, bp_halted}, 32'd1);
        check("skip_index", {30'd0, bp_index}, 32'd1);
        clk_auto_en = 1'b0; clk_step = 1'b0;
        @(negedge clk);
        check("halt_exit", {31'd0, bp_halted}, 32'd0);
        check("bp_count", ce_count, exp_ce);

        // Asynchronous reset mid-burst at steps_left 7, landing on a pulse cycle.
        bp_en = 4'b0000; div_ratio = 24'd2; step_count = 16'd10;
        repeat (4) @(negedge clk); n = cyc;
        clk_step = 1'b1;
        expect_ce(n + 7); expect_ce(n + 10); expect_ce(n + 13);
        repeat (13) @(negedge clk);
        check("pre_rst_steps", {16'd0, steps_left}, 32'd7);
        check("pre_rst_running", {31'd0, running}, 32'd1);
        #2 rst = 1'b0;
        #1;
        exp_ce = 0;
        check("arst_ce", {31'd0, cpu_ce}, 32'd0);
        check("arst_running", {31'd0, running}, 32'd0);
        check("arst_steps", {16'd0, steps_left}, 32'd0);
        check("arst_count", ce_count, 32'd0);
        clk_step = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_count", ce_count, 32'd0);

        // clk_auto_en and step_req together: free-run wins, step dropped.
        div_ratio = 24'd3; step_count = 16'd5;
        @(negedge clk); n = cyc;
        clk_step = 1'b1;
        repeat (3) @(negedge clk);
        clk_auto_en = 1'b1;
        expect_ce(n + 8);
        @(negedge clk);
        check("tie_running", {31'd0, running}, 32'd1);
        check("tie_steps", {16'd0, steps_left}, 32'd0);
        repeat (4) @(negedge clk);
        clk_auto_en = 1'b0;
        @(negedge clk);
        check("tie_stop", {31'd0, running}, 32'd0);
        clk_step = 1'b0;
        repeat (5) @(negedge clk);
        check("tie_count", ce_count, exp_ce);
        check("ce_missing", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
